// File: rtl/bus_copy_master.sv
// DataBus block-copy initiator: reads a word from src, writes it to dst, repeats len times.
// Optional running checksum of copied words: define BUS_COPY_CHECKSUM_EN.
module bus_copy_master #(
    parameter int LEN_W  = 16,
    parameter int STRIDE = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [31:0]      bus_addr,
    output logic             bus_read,
    output logic             bus_write,
    output logic [31:0]      bus_wdata,
    input  logic [31:0]      bus_rdata,
    input  logic             bus_ready
`ifdef BUS_COPY_CHECKSUM_EN
    ,
    output logic [31:0]      checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      src_q, dst_q, data_q;
    logic [LEN_W-1:0] rem_q;
`ifdef BUS_COPY_CHECKSUM_EN
    logic [31:0]      csum_q;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            state  <= S_IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            data_q <= '0;
            rem_q  <= '0;
`ifdef BUS_COPY_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_q <= {src_addr[31:2], 2'b00};
                        dst_q <= {dst_addr[31:2], 2'b00};
                        rem_q <= len;
`ifdef BUS_COPY_CHECKSUM_EN
                        csum_q <= '0;
`endif
                    end
                end
                S_CAP: data_q <= bus_rdata;
                S_WR: begin
                    // Both addresses advance only once the write is accepted.
                    if (bus_ready) begin
                        src_q <= src_q + 32'(STRIDE);
                        dst_q <= dst_q + 32'(STRIDE);
                        rem_q <= rem_q - LEN_W'(1);
`ifdef BUS_COPY_CHECKSUM_EN
                        csum_q <= csum_q + data_q;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        bus_read  = 1'b0;
        bus_write = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (len != '0) ? S_RD : S_DONE;
            end
            S_RD: begin
                busy     = 1'b1;
                bus_read = 1'b1;
                bus_addr = src_q;
                if (bus_ready) state_nxt = S_CAP;
            end
            S_CAP: begin
                busy      = 1'b1;
                state_nxt = S_WR;
            end
            S_WR: begin
                busy      = 1'b1;
                bus_write = 1'b1;
                bus_addr  = dst_q;
                bus_wdata = data_q;
                if (bus_ready) state_nxt = (rem_q == LEN_W'(1)) ? S_DONE : S_RD;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef BUS_COPY_CHECKSUM_EN
    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_bus_copy_master.sv
// Self-checking bench for bus_copy_master: memory slave with wait states plus a copy-level reference model.
module tb_bus_copy_master;

    logic        clk = 1'b0;
    logic        res, start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len;
    logic        busy, done, bus_read, bus_write, bus_ready;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
`ifdef BUS_COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clk = ~clk;

    bus_copy_master #(.LEN_W(16), .STRIDE(4)) dut (
        .clk(clk), .res(res), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done),
        .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
`ifdef BUS_COPY_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- memory slave ----------------
    logic [31:0] mem [logic [31:0]];
    int          nwait = 0;          // negative: random ready
    int          waits_left = 0;
    int          wait_cycles = 0;
    int          n_wr = 0;
    bit          pend = 0, waiting = 0;
    logic [31:0] pend_val, w_addr, w_data;
    logic        w_kind;
    logic        log_kind [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    function automatic logic [31:0] def_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return def_val(a);
    endfunction

    initial begin
        bus_ready = 1'b1;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            bus_rdata = pend ? pend_val : $urandom;
            pend = 0;
            if (res) begin
                waiting    = 0;
                waits_left = nwait;
                bus_ready  = 1'b1;
            end else if (bus_read || bus_write) begin
                check("excl_rd_wr", 32'(bus_read & bus_write), 32'd0);
                if (waiting) begin
                    check("hold_kind", 32'(bus_write), 32'(w_kind));
                    check("hold_addr", bus_addr, w_addr);
                    if (bus_write) check("hold_wdata", bus_wdata, w_data);
                end
                if (nwait < 0) bus_ready = ($urandom_range(0, 2) != 0);
                else begin
                    bus_ready = (waits_left == 0);
                    if (waits_left > 0) waits_left--;
                end
                if (!bus_ready) begin
                    waiting = 1;
                    w_kind  = bus_write;
                    w_addr  = bus_addr;
                    w_data  = bus_wdata;
                    wait_cycles++;
                end else begin
                    waiting    = 0;
                    waits_left = nwait;
                    log_kind.push_back(bus_write);
                    log_addr.push_back(bus_addr);
                    if (bus_write) begin
                        log_data.push_back(bus_wdata);
                        mem[bus_addr] = bus_wdata;
                        n_wr++;
                    end else begin
                        pend_val = mem_rd(bus_addr);
                        pend     = 1;
                        log_data.push_back(pend_val);
                    end
                end
            end else begin
                waiting   = 0;
                bus_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs(input int nw);
        nwait       = nw;
        waits_left  = nw;
        wait_cycles = 0;
        n_wr        = 0;
        log_kind.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    // One copy, checked against a word-by-word model of the copy semantics.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int l,
                            input int nw, input bit poke, output int cyc);
        logic [31:0] refm [logic [31:0]];
        logic        ek [$];
        logic [31:0] ea [$];
        logic [31:0] ed [$];
        logic [31:0] sa, da, v, csum;
        int          n;
        clear_logs(nw);
        refm = mem;
        sa   = {s[31:2], 2'b00};
        da   = {d[31:2], 2'b00};
        csum = '0;
        for (int i = 0; i < l; i++) begin
            v = refm.exists(sa) ? refm[sa] : def_val(sa);
            ek.push_back(1'b0); ea.push_back(sa); ed.push_back(v);
            ek.push_back(1'b1); ea.push_back(da); ed.push_back(v);
            refm[da] = v;
            csum += v;
            sa += 32'd4;
            da += 32'd4;
        end

        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = 16'(l);
        @(posedge clk);
        tick();
        start    = 1'b0;
        src_addr = $urandom;
        dst_addr = $urandom;
        len      = 16'($urandom);
        cyc = 1;
        forever begin
            if (done || cyc >= 600) break;
            check("busy_during", 32'(busy), 32'(l != 0));
            if (poke && cyc == 4) begin
                start = 1'b1;
                len   = 16'($urandom_range(1, 50));
            end else start = 1'b0;
            tick();
            cyc++;
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("done_cycle", 32'(cyc), 32'(3 * l + 1 + wait_cycles));
        check("busy_at_done", 32'(busy), 32'd0);
`ifdef BUS_COPY_CHECKSUM_EN
        check("checksum", checksum, csum);
`endif
        tick();
        check("done_pulse_end", 32'(done), 32'd0);
        for (int k = 0; k < 4; k++) tick();
        n = log_kind.size();
        check("n_txn", 32'(n), 32'(2 * l));
        for (int i = 0; i < n && i < ek.size(); i++) begin
            check("txn_kind", 32'(log_kind[i]), 32'(ek[i]));
            check("txn_addr", log_addr[i], ea[i]);
            check("txn_data", log_data[i], ed[i]);
        end
    endtask

    initial begin
        int cyc;
        int guard;
        res = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        tick(); tick();
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_read",  32'(bus_read), 32'd0);
        check("rst_write", 32'(bus_write), 32'd0);
        check("rst_addr",  bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
`ifdef BUS_COPY_CHECKSUM_EN
        check("rst_csum",  checksum, 32'd0);
`endif
        res = 1'b0;
        tick();

        mem[32'h40] = 32'd4;
        mem[32'h44] = 32'd5;
        mem[32'h48] = 32'd9;
        run_copy(32'h40, 32'h80, 3, 0, 0, cyc);
        check("basic_cycle", 32'(cyc), 32'd10);

        run_copy(32'h100, 32'h200, 2, 2, 0, cyc);
        check("wait_cycle", 32'(cyc), 32'd15);

        run_copy(32'h43, 32'h300, 0, 0, 0, cyc);
        check("zero_cycle", 32'(cyc), 32'd1);
        run_copy(32'h43, 32'h302, 2, 0, 0, cyc);

        // Abort during the second write's wait state, then copy again.
        clear_logs(2);
        start = 1'b1; src_addr = 32'h500; dst_addr = 32'h600; len = 16'd3;
        @(posedge clk);
        tick();
        start = 1'b0;
        guard = 0;
        while (!(bus_write && n_wr == 1 && !bus_ready) && guard < 200) begin
            tick();
            guard++;
        end
        check("abort_reached", 32'(guard < 200), 32'd1);
        res = 1'b1;
        @(posedge clk);
        tick();
        check("abort_read",  32'(bus_read), 32'd0);
        check("abort_write", 32'(bus_write), 32'd0);
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_done",  32'(done), 32'd0);
`ifdef BUS_COPY_CHECKSUM_EN
        check("abort_csum",  checksum, 32'd0);
`endif
        res = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("abort_quiet", 32'(done | bus_read | bus_write), 32'd0);
        end
        run_copy(32'h500, 32'h600, 3, 0, 0, cyc);

        run_copy(32'h700, 32'h800, 3, 1, 1, cyc);
        run_copy(32'hFFFFFFFC, 32'h900, 2, 0, 0, cyc);

        for (int r = 0; r < 8; r++) begin
            run_copy($urandom & 32'h3FF, $urandom & 32'h3FF,
                     int'($urandom_range(1, 6)), -1, 1'($urandom_range(0, 1)), cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bus_copy_master.md
Name: bus_copy_master

Overview:
- DataBus initiator that copies a block of 32-bit words from a source region to a destination region. It uses plain read/write transactions and honours slave wait states through ready.
- Sits alongside CPUCore as a second bus master. Its first use is loading program images into memory slaves before the core is released from reset. It also drives slaves directly in bus-level testbenches.

Parameters:
- LEN_W, 16, width of the word-count input; maximum transfer length is 2^LEN_W-1 words.
- STRIDE, 4, byte increment applied to both addresses after each word.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- res  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- src_addr  input  32  source byte address; bits [1:0] forced to 0 when latched.
- dst_addr  input  32  destination byte address; bits [1:0] forced to 0 when latched.
- len  input  LEN_W  number of words to copy.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse on completion.
- bus_addr  output  32  DataBus addr.
- bus_read  output  1  DataBus read.
- bus_write  output  1  DataBus write.
- bus_wdata  output  32  DataBus master-to-slave data.
- bus_rdata  input  32  DataBus slave-to-master data.
- bus_ready  input  1  DataBus ready.

Behaviour:
- Reset (synchronous, res=1 at posedge):
  - State goes to IDLE.
  - busy=0, done=0, bus_read=0, bus_write=0, bus_addr=0, bus_wdata=0.
  - Reset during a transfer aborts it on that edge: no done pulse, and no further bus activity.
- Bus rules:
  - A transaction is accepted on the posedge where (bus_read|bus_write)&bus_ready=1.
  - bus_read and bus_write are never both 1.
  - bus_addr and bus_wdata are held stable while waiting for bus_ready.
  - Read data is registered by the slave: it is valid on bus_rdata in the cycle after the accepting edge, and the master captures it at the next posedge.
- States:
  - IDLE:
    - start=1 with len!=0: latch src/dst/len, go to RD, set busy=1.
    - start=1 with len=0: pulse done in the next cycle, busy stays 0, no bus traffic.
    - start=0: stay in IDLE.
  - RD: bus_read=1, bus_addr=src. On accept, go to CAP.
  - CAP: no bus request. Capture bus_rdata into the data register and go to WR.
  - WR: bus_write=1, bus_addr=dst, bus_wdata=data register. On accept:
    - src += STRIDE, dst += STRIDE, remaining -= 1.
    - remaining becomes 0: go to DONE.
    - otherwise: go to RD.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Timing: with bus_ready tied to 1, each word takes 3 cycles. done is asserted exactly 3*len+1 cycles after the start-accepting edge.
- Addresses wrap modulo 2^32; there is no error on wrap.
- start while busy is ignored. Input changes after latching have no effect.
- Overlapping source and destination regions are copied word by word in ascending order; forward overlap therefore propagates data, which is by design.

Optional Feature:
- Macro: BUS_COPY_CHECKSUM_EN.
- Enabled:
  - Adds output checksum (32).
  - Cleared to 0 when start is accepted.
  - On each WR accept, checksum += copied word, modulo 2^32.
  - Value is held after done until the next accepted start; reset clears it.
- Disabled: the port and all related logic are absent; the rest of the behaviour is identical.

Test Plan:
- Basic copy: slave ready=1, mem[16..18]=4,5,9; start with src=0x40, dst=0x80, len=3.
  - Reads 0x40, 0x44, 0x48 and writes 0x80, 0x84, 0x88 with 4, 5, 9.
  - done pulses 10 cycles after the start edge.
  - checksum=18 when enabled.
- Wait states: slave drops ready for 2 cycles on every request; len=2.
  - addr and wdata are stable during each wait.
  - Exactly 2 reads and 2 writes occur; done arrives at cycle 2*(3+4)+1=15.
- Zero length and misaligned address: start with len=0 gives done the next cycle, busy=0, no read or write. src=0x43 is issued as 0x40.
- Reset mid-transfer: res=1 during the second WR wait.
  - Next cycle: read=write=0, busy=0, no done.
  - A new start afterwards copies correctly.
- Start while busy and address wrap:
  - A second start during a transfer is ignored (transfer count unchanged).
  - src=0xFFFFFFFC, len=2 reads 0xFFFFFFFC then 0x00000000.
